// File: rtl/sd_sector_writer_pkg.sv
// ============================================================================
// sd_sector_writer_pkg : shared types and constants for the SD sector writer
// Revision: 1.0
// ============================================================================
`default_nettype none

package sd_sector_writer_pkg;

  localparam int unsigned SECTOR_BYTES_DEF = 512;
  localparam int unsigned BUF_AW           = 9;

  typedef enum logic [2:0] {
    SW_IDLE       = 3'd0,
    SW_WAIT_READY = 3'd1,
    SW_ISSUE      = 3'd2,
    SW_STREAM     = 3'd3,
    SW_WAIT_DONE  = 3'd4
  } sw_state_e;

  // Word offsets of the writer registers inside the SD peripheral window.
  typedef enum logic [9:0] {
    SDC_WBUF_BASE = 10'h000,
    SDC_WADDR     = 10'h200,
    SDC_WSTART    = 10'h201,
    SDC_WSTAT     = 10'h202
  } sdc_wofs_e;

endpackage

`default_nettype wire

// File: rtl/sd_sector_buf.sv
// ============================================================================
// sd_sector_buf : sector byte store, write port A, registered read port B
// Revision: 1.0
// ============================================================================
`default_nettype none

module sd_sector_buf #(
  parameter int unsigned DEPTH = 512,
  parameter int unsigned AW    = 9
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [7:0]    wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [7:0]    rdata_o
);

  (* ram_style = "block" *) logic [7:0] mem_q [DEPTH];
  logic [7:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

`default_nettype wire

// File: rtl/sd_sector_writer.sv
// ============================================================================
// sd_sector_writer : streams a CPU-filled sector buffer into sd_controller
// Revision: 1.0
// ============================================================================
`default_nettype none

module sd_sector_writer
  import sd_sector_writer_pkg::*;
#(
  parameter int unsigned SECTOR_BYTES   = SECTOR_BYTES_DEF,
  parameter int unsigned TIMEOUT_CYCLES = 16777216
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        buf_we_i,
  input  logic [8:0]  buf_idx_i,
  input  logic [7:0]  buf_wdata_i,
  input  logic        addr_we_i,
  input  logic [31:0] addr_wdata_i,
  input  logic        start_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        error_o,
  output logic [9:0]  progress_o,
  input  logic        sd_ready_i,
  input  logic        sd_rfnb_i,
  output logic        sd_wr_o,
  output logic [7:0]  sd_din_o,
  output logic [31:0] sd_address_o
);

  localparam int unsigned  TW        = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [9:0]   FULL      = 10'(SECTOR_BYTES);
  localparam logic [9:0]   LAST_BYTE = 10'(SECTOR_BYTES - 1);

  sw_state_e       state_q, state_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            error_q, error_d;
  logic [9:0]      progress_q, progress_d;
  logic            sd_wr_q, sd_wr_d;
  logic [7:0]      sd_din_q, sd_din_d;
  logic [31:0]     sd_address_q, sd_address_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic            rfnb_q;
  logic            prime_q, prime_d;
  logic            low_seen_q, low_seen_d;

  logic              rfnb_edge;
  logic              tmo_hit;
  logic              buf_wr;
  logic [BUF_AW-1:0] rd_addr;
  logic [7:0]        rd_data;

  assign rfnb_edge = sd_rfnb_i & ~rfnb_q;
  assign tmo_hit   = (tmo_q == TMO_LAST) && !rfnb_edge;
  assign buf_wr    = buf_we_i && (state_q == SW_IDLE);

  // Read port always runs one byte ahead of what sd_din shows.
  always_comb begin
    rd_addr = '0;
    case (state_q)
      SW_ISSUE:  rd_addr = BUF_AW'(1);
      SW_STREAM: rd_addr = progress_q[BUF_AW-1:0] + BUF_AW'(1);
      default:   rd_addr = '0;
    endcase
  end

  sd_sector_buf #(
    .DEPTH (SECTOR_BYTES),
    .AW    (BUF_AW)
  ) u_buf (
    .clk_i   (clk_i),
    .we_i    (buf_wr),
    .waddr_i (buf_idx_i),
    .wdata_i (buf_wdata_i),
    .raddr_i (rd_addr),
    .rdata_o (rd_data)
  );

  always_comb begin
    state_d      = state_q;
    busy_d       = busy_q;
    done_d       = done_q;
    error_d      = error_q;
    progress_d   = progress_q;
    sd_wr_d      = 1'b0;
    sd_din_d     = sd_din_q;
    sd_address_d = sd_address_q;
    prime_d      = prime_q;
    low_seen_d   = low_seen_q;
    tmo_d        = '0;

    case (state_q)
      SW_IDLE: begin
        if (addr_we_i) begin
          sd_address_d = addr_wdata_i;
        end
        if (start_i) begin
          state_d    = SW_WAIT_READY;
          busy_d     = 1'b1;
          done_d     = 1'b0;
          error_d    = 1'b0;
          progress_d = '0;
          prime_d    = 1'b0;
        end
      end
      // The first cycle here lets a same-cycle buffer write reach the read port.
      SW_WAIT_READY: begin
        prime_d  = 1'b1;
        sd_din_d = rd_data;
        if (sd_ready_i && prime_q) begin
          state_d = SW_ISSUE;
          sd_wr_d = 1'b1;
        end
      end
      SW_ISSUE: begin
        state_d = SW_STREAM;
      end
      SW_STREAM: begin
        if (rfnb_edge && (progress_q < FULL)) begin
          progress_d = progress_q + 10'd1;
          if (progress_q == LAST_BYTE) begin
            state_d    = SW_WAIT_DONE;
            low_seen_d = 1'b0;
          end else begin
            sd_din_d = rd_data;
          end
        end
      end
      SW_WAIT_DONE: begin
        if (!sd_ready_i) begin
          low_seen_d = 1'b1;
        end else if (low_seen_q) begin
          state_d = SW_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = SW_IDLE;
        busy_d  = 1'b0;
      end
    endcase

    if ((state_q == SW_WAIT_READY || state_q == SW_STREAM || state_q == SW_WAIT_DONE)
        && (state_d == state_q) && tmo_hit) begin
      state_d = SW_IDLE;
      busy_d  = 1'b0;
      done_d  = 1'b1;
      error_d = 1'b1;
      sd_wr_d = 1'b0;
    end

    if ((state_q != SW_IDLE) && (state_d == state_q) && !rfnb_edge) begin
      tmo_d = tmo_q + TW'(1);
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q      <= SW_IDLE;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      progress_q   <= '0;
      sd_wr_q      <= 1'b0;
      sd_din_q     <= '0;
      sd_address_q <= '0;
      tmo_q        <= '0;
      rfnb_q       <= 1'b0;
      prime_q      <= 1'b0;
      low_seen_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      error_q      <= error_d;
      progress_q   <= progress_d;
      sd_wr_q      <= sd_wr_d;
      sd_din_q     <= sd_din_d;
      sd_address_q <= sd_address_d;
      tmo_q        <= tmo_d;
      rfnb_q       <= sd_rfnb_i;
      prime_q      <= prime_d;
      low_seen_q   <= low_seen_d;
    end
  end

  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign error_o      = error_q;
  assign progress_o   = progress_q;
  assign sd_wr_o      = sd_wr_q;
  assign sd_din_o     = sd_din_q;
  assign sd_address_o = sd_address_q;

endmodule

`default_nettype wire
